// File: rtl/lut_bool_eval.sv
// Programmable N-input truth-table evaluator with serial table load and self-sweep.
// Optional macro LUT_READBACK_EN adds cfg_sout, the table MSB that shifts out on each load.
module lut_bool_eval #(
    parameter int N          = 5,
    parameter int SWEEP_HOLD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    input  logic         cfg_bit,
    input  logic [N-1:0] in_vec,
    input  logic         eval_en,
    output logic         f_out,
    output logic         f_valid,
    input  logic         sweep_start,
    output logic         sweep_busy,
    output logic [N-1:0] sweep_idx,
    output logic         sweep_f,
    output logic         sweep_done,
`ifdef LUT_READBACK_EN
    output logic         cfg_sout,
`endif
    output logic [N:0]   minterm_cnt
);

    localparam int           DEPTH     = 1 << N;
    localparam logic [N-1:0] IDX_LAST  = N'(DEPTH - 1);
    localparam logic [7:0]   HOLD_LAST = 8'(SWEEP_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [DEPTH-1:0] tt;
    logic [7:0]       hold_cnt;

    // Loading is only allowed in IDLE so a sweep always reads a stable table.
    always_ff @(posedge clk) begin
        if (rst) begin
            tt <= '0;
        end else if (cfg_load && (state == S_IDLE)) begin
            tt <= {tt[DEPTH-2:0], cfg_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_out   <= 1'b0;
            f_valid <= 1'b0;
        end else begin
            f_valid <= eval_en;
            if (eval_en) begin
                f_out <= tt[in_vec];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sweep_idx   <= '0;
            hold_cnt    <= '0;
            minterm_cnt <= '0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sweep_start) begin
                        state       <= S_RUN;
                        sweep_busy  <= 1'b1;
                        sweep_idx   <= '0;
                        hold_cnt    <= '0;
                        minterm_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        minterm_cnt <= minterm_cnt + (N+1)'(tt[sweep_idx]);
                        // Index stops at the last entry; it never wraps back to 0.
                        if (sweep_idx == IDX_LAST) begin
                            state      <= S_DONE;
                            sweep_busy <= 1'b0;
                            sweep_done <= 1'b1;
                        end else begin
                            sweep_idx <= sweep_idx + 1'b1;
                            hold_cnt  <= '0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    sweep_busy <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_f = sweep_busy & tt[sweep_idx];

`ifdef LUT_READBACK_EN
    assign cfg_sout = tt[DEPTH-1];
`endif

endmodule

// File: tb/tb_lut_bool_eval.sv
// Bench for lut_bool_eval (N=5, SWEEP_HOLD=1): directed vectors, behavioural model, per-cycle compare.
// Exercises cfg_sout as well when LUT_READBACK_EN is defined.
module tb_lut_bool_eval;

    localparam int N     = 5;
    localparam int HOLD  = 1;
    localparam int DEPTH = 1 << N;
    localparam int TOTAL = DEPTH * HOLD;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_load = 1'b0;
    logic         cfg_bit = 1'b0;
    logic [N-1:0] in_vec = '0;
    logic         eval_en = 1'b0;
    logic         sweep_start = 1'b0;
    logic         f_out, f_valid, sweep_busy, sweep_f, sweep_done;
    logic [N-1:0] sweep_idx;
    logic [N:0]   minterm_cnt;
`ifdef LUT_READBACK_EN
    logic         cfg_sout;
`endif

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;
    int done_pulses = 0;

    lut_bool_eval #(.N(N), .SWEEP_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_bit(cfg_bit),
        .in_vec(in_vec), .eval_en(eval_en), .f_out(f_out), .f_valid(f_valid),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_idx(sweep_idx),
        .sweep_f(sweep_f), .sweep_done(sweep_done),
`ifdef LUT_READBACK_EN
        .cfg_sout(cfg_sout),
`endif
        .minterm_cnt(minterm_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep tracked as a count of RUN cycles since start.
    logic [DEPTH-1:0] m_tt;
    logic             m_f, m_fv;
    int               pos, m_idx, m_cnt;

    function automatic int ones_below(input int k);
        int c = 0;
        for (int i = 0; i < DEPTH; i++)
            if (i < k && m_tt[i]) c++;
        return c;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_tt = '0; m_f = 1'b0; m_fv = 1'b0;
            pos = -1; m_idx = 0; m_cnt = 0;
        end else begin
            m_fv = eval_en;
            if (eval_en) m_f = m_tt[in_vec];
            if (pos < 0) begin
                if (cfg_load) m_tt = {m_tt[DEPTH-2:0], cfg_bit};
                if (sweep_start) pos = 0;
            end else if (pos == TOTAL) begin
                pos = -1;
            end else begin
                pos = pos + 1;
            end
            if (pos >= 0) begin
                m_idx = (pos / HOLD < DEPTH) ? pos / HOLD : DEPTH - 1;
                m_cnt = ones_below(pos / HOLD);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic m_busy;
            m_busy = (pos >= 0) && (pos < TOTAL);
            check("f_out", 32'(f_out), 32'(m_f));
            check("f_valid", 32'(f_valid), 32'(m_fv));
            check("sweep_busy", 32'(sweep_busy), 32'(m_busy));
            check("sweep_done", 32'(sweep_done), 32'(pos == TOTAL));
            check("sweep_idx", 32'(sweep_idx), 32'(m_idx));
            check("sweep_f", 32'(sweep_f), 32'(m_busy ? m_tt[m_idx] : 1'b0));
            check("minterm_cnt", 32'(minterm_cnt), 32'(m_cnt));
`ifdef LUT_READBACK_EN
            check("cfg_sout", 32'(cfg_sout), 32'(m_tt[DEPTH-1]));
`endif
            if (sweep_done === 1'b1) done_pulses++;
        end
    end

    // Inputs change 1 time unit after the falling edge, after the compare has sampled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w, input bit start_on_last);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cfg_load = 1'b1;
            cfg_bit  = w[i];
            sweep_start = (start_on_last && i == 0);
            step();
        end
        cfg_load = 1'b0;
        sweep_start = 1'b0;
    endtask

    task automatic eval_lit(input logic [N-1:0] v, input logic exp);
        in_vec  = v;
        eval_en = 1'b1;
        step();
        eval_en = 1'b0;
        check("eval_lit_f", 32'(f_out), 32'(exp));
        check("eval_lit_valid", 32'(f_valid), 32'd1);
    endtask

    // Runs until sweep_done is seen; returns number of busy cycles observed.
    task automatic run_sweep(output int busy_cycles);
        int budget;
        busy_cycles = 0;
        budget = 0;
        while (sweep_done !== 1'b1 && budget < 400) begin
            if (sweep_busy === 1'b1) busy_cycles++;
            step();
            budget++;
        end
        check("sweep_done_seen", 32'(sweep_done === 1'b1), 32'd1);
    endtask

    task automatic wait_idx(input int target);
        int budget = 0;
        while (sweep_idx !== N'(target) && budget < 100) begin
            step();
            budget++;
        end
        check("wait_idx", 32'(sweep_idx), 32'(target));
    endtask

    initial begin
        int busy;
        int pulses_before;
        logic [31:0] rb;

        rst = 1'b1;
        step();
        step();
        started = 1'b1;
        check("rst_f_out", 32'(f_out), 32'd0);
        check("rst_f_valid", 32'(f_valid), 32'd0);
        check("rst_busy", 32'(sweep_busy), 32'd0);
        check("rst_done", 32'(sweep_done), 32'd0);
        check("rst_cnt", 32'(minterm_cnt), 32'd0);
        rst = 1'b0;
        step();

        load_word(32'hA5A5_0F0F, 1'b0);
        eval_lit(5'b11101, 1'b1);
        eval_lit(5'b00000, 1'b1);
        eval_lit(5'b00101, 1'b0);
        eval_lit(5'b00010, 1'b1);

        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        run_sweep(busy);
        check("busy_cycles", 32'(busy), 32'd32);
        step();
        check("minterm_a5", 32'(minterm_cnt), 32'd16);
        check("done_once", 32'(done_pulses), 32'd1);

        // Same-cycle eval and load: eval sees the old table; last load bit also starts a sweep.
        eval_en = 1'b1;
        in_vec  = 5'b00101;
        cfg_load = 1'b1;
        cfg_bit  = 1'b1;
        step();
        eval_en = 1'b0;
        check("eval_old_table", 32'(f_out), 32'd0);
        load_word(32'hFFFF_FFFF, 1'b1);
        run_sweep(busy);
        step();
        check("minterm_ones", 32'(minterm_cnt), 32'd32);

        // Mid-sweep load/start must be ignored.
        load_word(32'hA5A5_0F0F, 1'b0);
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        wait_idx(10);
        cfg_load = 1'b1;
        cfg_bit  = 1'b1;
        sweep_start = 1'b1;
        step();
        cfg_load = 1'b0;
        sweep_start = 1'b0;
        check("no_restart_idx", 32'(sweep_idx), 32'd11);
        run_sweep(busy);
        step();
        check("minterm_after_ignored", 32'(minterm_cnt), 32'd16);
        eval_lit(5'b00101, 1'b0);

        // Reset mid-sweep aborts with no done pulse and clears the table.
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        wait_idx(12);
        pulses_before = done_pulses;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_busy", 32'(sweep_busy), 32'd0);
        check("abort_idx", 32'(sweep_idx), 32'd0);
        for (int i = 0; i < 40; i++) step();
        check("abort_no_done", 32'(done_pulses), 32'(pulses_before));
        eval_lit(5'b11101, 1'b0);
        eval_lit(5'b00000, 1'b0);

`ifdef LUT_READBACK_EN
        load_word(32'hA5A5_0F0F, 1'b0);
        rb = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rb[i] = cfg_sout;
            cfg_load = 1'b1;
            cfg_bit  = 1'b0;
            step();
        end
        cfg_load = 1'b0;
        check("readback", rb, 32'hA5A5_0F0F);
        check("readback_cleared", 32'(cfg_sout), 32'd0);
`else
        rb = '0;
`endif

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lut_bool_eval.md
Name: lut_bool_eval

Overview:
- Parametrised, programmable successor to the fixed 5-input boolean function block.
- Holds an N-input truth table (2^N bits) loaded serially at run time.
- Evaluates the table for an applied input vector with a registered output.
- Self-sweep mode walks every input combination, streams index and value, and counts minterms (ones in the table).
- Sits between the lab switch/stimulus logic and the LED/display or checker logic.

Parameters:
- N, 5, number of function inputs (2..8); table depth is 2^N.
- SWEEP_HOLD, 1, cycles each index is held during a sweep (1..255); lets slow display logic follow.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_load  input  1  shift one table bit in this cycle.
- cfg_bit  input  1  table bit to shift in.
- in_vec  input  N  function inputs, MSB = first variable (V for N=5).
- eval_en  input  1  request evaluation of in_vec.
- f_out  output  1  registered function value.
- f_valid  output  1  one-cycle pulse: f_out updated this cycle.
- sweep_start  input  1  start a full-table sweep.
- sweep_busy  output  1  high while sweep FSM is in RUN.
- sweep_idx  output  N  current sweep index.
- sweep_f  output  1  table value at sweep_idx; valid while sweep_busy.
- sweep_done  output  1  one-cycle pulse at sweep end.
- minterm_cnt  output  N+1  number of ones found by the last sweep.

Behaviour:
- Reset (rst=1 at clk edge) clears:
  - table tt[2^N-1:0] to 0;
  - f_out, f_valid, sweep_idx, sweep_done, minterm_cnt to 0;
  - hold counter to 0;
  - FSM to IDLE, so sweep_busy=0 and sweep_f=0.
- Reset mid-sweep aborts the sweep with no sweep_done pulse. rst has priority over all inputs.
- Table load:
  - When cfg_load=1 and FSM is IDLE, the table shifts left: tt <= {tt[2^N-2:0], cfg_bit}.
  - After 2^N loads, the first bit loaded sits in tt[2^N-1], i.e. MSB-first by minterm index.
  - cfg_load is ignored while FSM is in RUN or DONE.
- Evaluation:
  - eval_en=1 at edge k gives f_out = tt[in_vec] and f_valid=1 after edge k. Latency 1 cycle.
  - The table used is the one before any same-cycle cfg_load shift.
  - eval_en=0: f_valid=0 and f_out holds its value.
  - Evaluation works in every FSM state; it is independent of the sweep.
- Sweep FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - On sweep_start=1: go to RUN; sweep_idx<=0, minterm_cnt<=0, hold counter<=0.
  - sweep_start in the same cycle as cfg_load: the load happens first (IDLE), then the sweep starts.
- RUN:
  - sweep_busy=1; sweep_f = tt[sweep_idx] (combinational from registered index).
  - Hold counter counts 0..SWEEP_HOLD-1. On its last count:
    - minterm_cnt += tt[sweep_idx];
    - if sweep_idx == 2^N-1, go to DONE; otherwise increment sweep_idx and clear the hold counter.
  - sweep_start is ignored in RUN.
- DONE:
  - One cycle with sweep_done=1, sweep_busy=0; then go to IDLE.
  - sweep_idx holds 2^N-1.
- Sweep length is 2^N*SWEEP_HOLD RUN cycles plus 1 DONE cycle.
- minterm_cnt is N+1 bits so an all-ones table reads exactly 2^N without wrap. It holds until the next sweep_start or rst.
- sweep_idx never wraps; the terminal check is on 2^N-1.

Optional Feature:
- Macro: LUT_READBACK_EN.
- Defined:
  - Adds output cfg_sout (1 bit) = tt[2^N-1], the bit that shifts out on each cfg_load.
  - Reading 2^N bits while reloading returns the previous table, MSB first.
  - cfg_sout resets to 0 with the table.
- Undefined: the port is absent and no extra logic is built. All other behaviour is identical.

Test Plan (N=5, SWEEP_HOLD=1):
- Reset: assert rst 2 cycles -> f_out=0, f_valid=0, sweep_busy=0, sweep_done=0, minterm_cnt=0.
- Load 32'hA5A5_0F0F MSB-first over 32 cfg_load cycles, then eval:
  - in_vec=5'b11101 -> f_out=1, one cycle later with f_valid pulse;
  - 5'b00000 -> 1;
  - 5'b00101 -> 0;
  - 5'b00010 -> 1.
- Sweep on the same table:
  - sweep_start pulse -> sweep_busy high exactly 32 cycles;
  - sweep_idx goes 0..31 and sweep_f matches table bits;
  - sweep_done pulses once, then minterm_cnt=16.
- Load all-ones table and sweep -> minterm_cnt=6'b100000 (32), no wrap.
- Mid-sweep events: cfg_load and sweep_start while sweep_idx=10 -> table unchanged, no restart. Assert rst while sweep_idx=12 -> next cycle IDLE, sweep_done never pulses, table=0.
- LUT_READBACK_EN defined: reload with 32'h0000_0000 after 32'hA5A5_0F0F -> cfg_sout sequence equals A5A50F0F MSB-first.
